// File: rtl/decode_issue.sv
// RV32I ALU-subset decode and issue stage: register file, pending-write scoreboard,
// same-cycle writeback bypass and a one-entry valid/ready output register.
module decode_issue (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  aluop,
   output logic [31:0] r1,
   output logic [31:0] r2,
   output logic [4:0]  rd,
   output logic        rd_we,
   output logic        illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   logic [31:0] rf_q [32];
   logic [31:0] pending_q, pending_d;

   logic        out_valid_q, out_valid_d;
   logic [4:0]  aluop_q, aluop_d;
   logic [31:0] r1_q, r1_d;
   logic [31:0] r2_q, r2_d;
   logic [4:0]  rd_q, rd_d;
   logic        rd_we_q, rd_we_d;
   logic        illegal_q, illegal_d;

   logic [4:0]  rs1, rs2, dst;
   logic [2:0]  funct3;
   logic        is_op, is_op_imm, legal;
   logic        rs1_byp, rs2_byp;
   logic [31:0] rs1_val, rs2_val;
   logic        hazard, accept;
   logic [4:0]  dec_aluop;
   logic [31:0] dec_r1, dec_r2;
   logic        dec_rd_we;

   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign dst    = in_instr[11:7];
   assign funct3 = in_instr[14:12];

   always_comb begin
      is_op     = (in_instr[6:0] == OPC_OP);
      is_op_imm = (in_instr[6:0] == OPC_OP_IMM);
      legal     = is_op | is_op_imm;

      // A writeback landing this cycle is forwarded and never counts as a hazard.
      rs1_byp = wb_en && (wb_rd == rs1) && (rs1 != 5'd0);
      rs2_byp = wb_en && (wb_rd == rs2) && (rs2 != 5'd0);

      rs1_val = 32'd0;
      if (rs1_byp)           rs1_val = wb_data;
      else if (rs1 != 5'd0)  rs1_val = rf_q[rs1];
      rs2_val = 32'd0;
      if (rs2_byp)           rs2_val = wb_data;
      else if (rs2 != 5'd0)  rs2_val = rf_q[rs2];

      hazard = (pending_q[rs1] & ~rs1_byp) | (is_op & pending_q[rs2] & ~rs2_byp);

      dec_aluop = {2'b00, funct3};
      if (funct3 == 3'b000 && is_op && in_instr[30]) dec_aluop = 5'd9;
      if (funct3 == 3'b101 && in_instr[30])          dec_aluop = 5'd8;

      dec_r1 = rs1_val;
      if (is_op)                                        dec_r2 = rs2_val;
      else if (funct3 == 3'b001 || funct3 == 3'b101)    dec_r2 = {27'd0, in_instr[24:20]};
      else                                              dec_r2 = {{20{in_instr[31]}}, in_instr[31:20]};
      dec_rd_we = legal && (dst != 5'd0);

      if (!legal) begin
         dec_aluop = 5'd0;
         dec_r1    = 32'd0;
         dec_r2    = 32'd0;
      end
   end

   assign in_ready = (~out_valid_q | out_ready) & ~hazard;
   assign accept   = in_valid & in_ready;

   // Set beats clear when the same register is both issued and written back.
   always_comb begin
      pending_d = pending_q;
      if (wb_en && wb_rd != 5'd0) pending_d[wb_rd] = 1'b0;
      if (accept && dec_rd_we)    pending_d[dst]   = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      aluop_d     = aluop_q;
      r1_d        = r1_q;
      r2_d        = r2_q;
      rd_d        = rd_q;
      rd_we_d     = rd_we_q;
      illegal_d   = illegal_q;
      if (accept) begin
         out_valid_d = 1'b1;
         aluop_d     = dec_aluop;
         r1_d        = dec_r1;
         r2_d        = dec_r2;
         rd_d        = dst;
         rd_we_d     = dec_rd_we;
         illegal_d   = ~legal;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
         pending_q   <= 32'd0;
         out_valid_q <= 1'b0;
         aluop_q     <= 5'd0;
         r1_q        <= 32'd0;
         r2_q        <= 32'd0;
         rd_q        <= 5'd0;
         rd_we_q     <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         if (wb_en && wb_rd != 5'd0) rf_q[wb_rd] <= wb_data;
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         aluop_q     <= aluop_d;
         r1_q        <= r1_d;
         r2_q        <= r2_d;
         rd_q        <= rd_d;
         rd_we_q     <= rd_we_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid = out_valid_q;
   assign aluop     = aluop_q;
   assign r1        = r1_q;
   assign r2        = r2_q;
   assign rd        = rd_q;
   assign rd_we     = rd_we_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios plus random traffic checked against
// an instruction-level model of the register file, scoreboard and issue register.
module tb_decode_issue;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = 32'd0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   logic [31:0] wb_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [4:0]  aluop;
   logic [31:0] r1, r2;
   logic [4:0]  rd;
   logic        rd_we;
   logic        illegal;

   decode_issue dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .aluop(aluop), .r1(r1), .r2(r2), .rd(rd), .rd_we(rd_we), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Reference state, kept at instruction level.
   logic [31:0] m_rf [32];
   bit          m_pend [32];
   bit          m_ov;
   logic [4:0]  m_aluop;
   logic [31:0] m_r1, m_r2;
   logic [4:0]  m_rd;
   bit          m_rdwe, m_ill;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin m_rf[i] = 32'd0; m_pend[i] = 0; end
      m_ov = 0; m_aluop = 0; m_r1 = 0; m_r2 = 0; m_rd = 0; m_rdwe = 0; m_ill = 0;
   endtask

   function automatic logic [31:0] read_reg(input int idx, input bit wbe, input int wbr, input logic [31:0] wbd);
      if (idx == 0) return 32'd0;
      if (wbe && wbr == idx) return wbd;
      return m_rf[idx];
   endfunction

   // One clock: drive at the falling edge, check just after, then advance the model.
   task automatic cycle(input bit iv, input logic [31:0] ins, input bit wbe,
                        input int wbr, input logic [31:0] wbd, input bit ordy);
      int op7, f3, s1, s2, d;
      bit is_op, is_imm, haz, rdy;
      logic [31:0] imm;
      @(negedge clk);
      in_valid = iv; in_instr = ins; wb_en = wbe; wb_rd = wbr[4:0]; wb_data = wbd; out_ready = ordy;
      #1;
      op7 = int'(ins[6:0]); f3 = int'(ins[14:12]);
      s1 = int'(ins[19:15]); s2 = int'(ins[24:20]); d = int'(ins[11:7]);
      is_op = (op7 == 'h33); is_imm = (op7 == 'h13);
      haz = (m_pend[s1] && !(wbe && wbr == s1 && s1 != 0)) ||
            (is_op && m_pend[s2] && !(wbe && wbr == s2 && s2 != 0));
      rdy = (!m_ov || ordy) && !haz;
      check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      if (m_ov) begin
         check("aluop", {27'd0, aluop}, {27'd0, m_aluop});
         check("r1", r1, m_r1);
         check("r2", r2, m_r2);
         check("rd", {27'd0, rd}, {27'd0, m_rd});
         check("rd_we", {31'd0, rd_we}, {31'd0, m_rdwe});
         check("illegal", {31'd0, illegal}, {31'd0, m_ill});
      end
      if (iv && rdy) begin
         m_ov = 1; m_rd = d[4:0]; m_ill = !(is_op || is_imm);
         if (m_ill) begin
            m_aluop = 0; m_r1 = 0; m_r2 = 0; m_rdwe = 0;
         end else begin
            m_aluop = f3[4:0];
            if (f3 == 0 && is_op && ins[30]) m_aluop = 9;
            if (f3 == 5 && ins[30]) m_aluop = 8;
            m_r1 = read_reg(s1, wbe, wbr, wbd);
            imm = 32'(signed'(ins[31:20]));
            if (is_op) m_r2 = read_reg(s2, wbe, wbr, wbd);
            else if (f3 == 1 || f3 == 5) m_r2 = 32'(s2);
            else m_r2 = imm;
            m_rdwe = (d != 0);
         end
      end else if (ordy) begin
         m_ov = 0;
      end
      if (wbe && wbr != 0) begin m_rf[wbr] = wbd; m_pend[wbr] = 0; end
      if (iv && rdy && m_rdwe && !m_ill) m_pend[d] = 1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_aluop"}, {27'd0, aluop}, 32'd0);
      check({tag, "_r1"}, r1, 32'd0);
      check({tag, "_r2"}, r2, 32'd0);
      check({tag, "_rd"}, {27'd0, rd}, 32'd0);
      check({tag, "_rd_we"}, {31'd0, rd_we}, 32'd0);
      check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
   endtask

   // Asynchronous reset, asserted between clock edges.
   task automatic pulse_reset();
      @(negedge clk);
      in_valid = 0; wb_en = 0; out_ready = 1;
      #2 reset = 1'b0;
      #1 check_reset_outputs("rst");
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      model_clear();
      @(negedge clk);
      #2 reset = 1'b1;
   endtask

   function automatic logic [31:0] rand_instr();
      int k;
      logic [31:0] w;
      k = $urandom_range(0, 9);
      w = $urandom;
      w[19:15] = 5'($urandom_range(0, 7));
      w[11:7]  = 5'($urandom_range(0, 7));
      if (k <= 3) begin
         w[24:20] = 5'($urandom_range(0, 7));
         w[31:25] = {1'b0, w[30], 5'd0};
         w[6:0] = 7'b0110011;
      end else if (k <= 7) begin
         w[6:0] = 7'b0010011;
      end else if (k == 8) begin
         w[6:0] = 7'b0000011;
      end
      return w;
   endfunction

   initial begin
      model_clear();
      #1 check_reset_outputs("por");
      check("por_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;

      // Writeback x1=5, then ADDI x2,x1,-3.
      cycle(0, 0, 1, 1, 32'd5, 1);
      cycle(1, 32'hFFD08113, 0, 0, 0, 1);
      cycle(0, 0, 1, 2, 32'd7, 1);
      check("addi_aluop", {27'd0, aluop}, 32'd0);
      check("addi_r1", r1, 32'd5);
      check("addi_r2", r2, 32'hFFFFFFFD);
      check("addi_rd", {27'd0, rd}, 32'd2);
      check("addi_rd_we", {31'd0, rd_we}, 32'd1);

      // SUB x3,x1,x2 then dependent ADD x4,x3,x1 waits for x3 writeback.
      cycle(1, 32'h402081B3, 0, 0, 0, 1);
      cycle(1, 32'h00118233, 0, 0, 0, 1);
      check("raw_stall", {31'd0, in_ready}, 32'd0);
      cycle(1, 32'h00118233, 0, 0, 0, 1);
      cycle(1, 32'h00118233, 1, 3, 32'h77, 1);
      check("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
      cycle(0, 0, 1, 4, 32'h11, 1);
      check("raw_bypass_r1", r1, 32'h77);

      // SRAI / SRLI x5,x1,4.
      cycle(1, 32'h4040D293, 0, 0, 0, 1);
      cycle(0, 0, 1, 5, 32'h1, 1);
      check("srai_aluop", {27'd0, aluop}, 32'd8);
      check("srai_r2", r2, 32'd4);
      cycle(1, 32'h0040D293, 0, 0, 0, 1);
      cycle(0, 0, 1, 5, 32'h2, 1);
      check("srli_aluop", {27'd0, aluop}, 32'd5);
      check("srli_r2", r2, 32'd4);

      // Output back-pressure for three cycles.
      cycle(1, 32'h00108313, 0, 0, 0, 1);
      repeat (3) begin
         cycle(1, 32'h00208393, 0, 0, 0, 0);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      cycle(1, 32'h00208393, 0, 0, 0, 1);
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);

      // Load opcode is issued as illegal and sets no pending bit.
      cycle(1, 32'h0000A183, 0, 0, 0, 1);
      cycle(1, 32'h00018433, 0, 0, 0, 1);
      check("load_illegal", {31'd0, illegal}, 32'd1);
      check("load_rd_we", {31'd0, rd_we}, 32'd0);
      check("load_aluop", {27'd0, aluop}, 32'd0);
      check("load_no_pending", {31'd0, in_ready}, 32'd1);

      // Reset in the middle of a stall on pending x3.
      cycle(1, 32'h00008193, 0, 0, 0, 1);
      cycle(1, 32'h00118233, 0, 0, 0, 0);
      cycle(1, 32'h00118233, 0, 0, 0, 0);
      pulse_reset();
      cycle(1, 32'h00118233, 0, 0, 0, 1);
      check("post_rst_ready", {31'd0, in_ready}, 32'd1);

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         bit wbe;
         wbe = ($urandom_range(0, 2) != 0);
         cycle($urandom_range(0, 3) != 0, rand_instr(), wbe, $urandom_range(0, 8),
               $urandom, $urandom_range(0, 3) != 0);
      end
      pulse_reset();
      cycle(0, 0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
